bayer_binning_demosaic: RTL and testbench
=========================================

# bayer_binning_demosaic

Single-clock, streaming 2×2 Bayer demosaic for the camera pipeline: consumes raw sensor pixels with a per-pixel qualifier and emits one half-resolution RGB pixel per 2×2 Bayer quad. It sits between the sensor capture logic and the image FIFO/compression path. Colour-filter pattern and pixel width are run-time and build-time selectable. A crop window is applied in output-pixel coordinates, and line-overflow errors are reported.

## Interface
Parameters:
- PIXEL_WIDTH, 10, bits per raw and per output colour sample
- MAX_X_SIZE, 1288, maximum raw pixels per line (even); line buffer holds MAX_X_SIZE/2 words of 2·PIXEL_WIDTH bits
- COORD_WIDTH, 11, width of internal x/y counters and crop inputs

Ports:
- clock_in  input  1  single pipeline clock
- reset_in  input  1  asynchronous, active-high reset
- pixel_data_in  input  PIXEL_WIDTH  raw Bayer sample
- pixel_valid_in  input  1  pixel_data_in is sampled on this edge
- line_valid_in  input  1  high for the duration of a raw line
- frame_valid_in  input  1  high for the duration of a frame
- bayer_pattern_in  input  2  0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR; latched at frame start
- x_offset_in, x_size_in  input  COORD_WIDTH  crop window, output-pixel units
- y_offset_in, y_size_in  input  COORD_WIDTH  crop window, output-pixel units
- rgb_out  output  3·PIXEL_WIDTH  {r, g, b}
- rgb_valid_out  output  1  rgb_out valid this cycle
- line_end_out  output  1  one-cycle pulse after the last in-window pixel of an output row
- frame_end_out  output  1  one-cycle pulse on the falling edge of frame_valid_in
- overflow_out  output  1  sticky: a line exceeded MAX_X_SIZE this frame

## Operation
- Arming: after reset, or while frame_valid_in is low, the block is idle. On a 0→1 edge of frame_valid_in it latches bayer_pattern_in and the crop inputs, clears x/y/row counters, and clears overflow_out. A reset in mid-frame leaves the block idle until the next rising edge; no partial frame is emitted.
- Raw x counts sampled pixels within a line; the falling edge of line_valid_in resets x and increments raw row.
- Even raw row: even-x sample held in a register; on odd-x sample, {even, odd} is written to the buffer at address x/2.
- Odd raw row: on even-x sample, the buffer is read at x/2 (1-cycle read) and the sample is held; on odd-x sample, the quad is complete and is computed.
- Quad samples are p00 and p01 from the buffer, p10 and p11 from the current line. Pattern mapping:
  - RGGB: r=p00, b=p11, greens p01/p10
  - GRBG: r=p01, b=p10, greens p00/p11
  - GBRG: b=p01, r=p10, greens p00/p11
  - BGGR: b=p00, r=p11, greens p01/p10
- g = (g_a + g_b) >> 1, computed at PIXEL_WIDTH+1 bits and truncated; there is no other arithmetic.
- Output coordinates are ox = x/2 and oy = row/2. A pixel is emitted only if x_offset ≤ ox < x_offset + x_size and y_offset ≤ oy < y_offset + y_size. A size of 0 emits nothing.
- Odd-length line: the trailing unpaired pixel is dropped. If the frame has an odd row count, the final unpaired row is dropped.
- Overflow: samples with x ≥ MAX_X_SIZE are discarded (no write, no read, no output) and overflow_out is set. overflow_out holds until the next frame arm or reset.
- line_end_out pulses the cycle after the line_valid_in falling edge of an odd raw row, if that row's oy is inside the window.

## Timing
- Reset values: rgb_out 0, rgb_valid_out 0, line_end_out 0, frame_end_out 0, overflow_out 0; all counters 0; idle.
- Latency: rgb_out and rgb_valid_out are registered and asserted the cycle after the odd-x sample of an odd row is accepted.
- Throughput: pixel_valid_in may be high every cycle, giving at most one output per two input cycles. Gaps in pixel_valid_in are allowed anywhere.
- The buffer read data issued on the even-x sample must remain held until the odd-x sample arrives, regardless of the gap length.
- rgb_valid_out is never high while frame_valid_in has been low for more than one cycle.
- If a line_valid_in falling edge and frame_valid_in falling edge coincide, both row increment and frame_end_out occur; frame_end_out is still a single pulse.

## Structure
- Package camera_pkg: bayer_pattern_t enum (RGGB, GRBG, GBRG, BGGR) and the pattern-to-quad-position mapping function.
- Sub-module line_buffer_ram: single-port synchronous RAM, depth MAX_X_SIZE/2, width 2·PIXEL_WIDTH, registered read. Even rows only write and odd rows only read, so one port suffices.

## Test plan
- RGGB, 4×2 frame with raw rows [100,200,300,400] and [500,600,700,800], full window → two outputs {100,350,600} then {300,550,800}, each 1 cycle after its odd sample; line_end_out pulses once.
- Same data with pattern BGGR → {600,350,100}, {800,550,300}; changing bayer_pattern_in mid-frame has no effect until the next frame.
- 8×8 frame with x_offset=1, x_size=2, y_offset=2, y_size=1 → exactly 2 outputs, ox=1,2 and oy=2.
- Line of MAX_X_SIZE+3 samples → overflow_out rises on the first excess sample, outputs stop at ox=MAX_X_SIZE/2−1, and overflow_out clears at the next frame arm.
- pixel_valid_in with random gaps of 0–5 cycles → output identical to the gap-free run.
- reset_in asserted mid-frame, frame_valid_in kept high → all outputs 0 and no output until frame_valid_in falls and rises again.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared camera-pipeline types: Bayer colour-filter patterns and the mapping
// from pattern to the quad positions holding red, the two greens and blue.
package camera_pkg;

   typedef enum logic [1:0] {
      RGGB = 2'd0,
      GRBG = 2'd1,
      GBRG = 2'd2,
      BGGR = 2'd3
   } bayer_pattern_t;

   // Quad positions: row 0 comes from the line buffer, row 1 from the current line
   typedef enum logic [1:0] {
      POS_00 = 2'd0,
      POS_01 = 2'd1,
      POS_10 = 2'd2,
      POS_11 = 2'd3
   } quad_pos_t;

   typedef struct packed {
      quad_pos_t r;
      quad_pos_t g_a;
      quad_pos_t g_b;
      quad_pos_t b;
   } quad_map_t;

   function automatic quad_map_t quad_map(input bayer_pattern_t pattern);
      quad_map_t m;
      case (pattern)
         RGGB:    m = '{r: POS_00, g_a: POS_01, g_b: POS_10, b: POS_11};
         GRBG:    m = '{r: POS_01, g_a: POS_00, g_b: POS_11, b: POS_10};
         GBRG:    m = '{r: POS_10, g_a: POS_00, g_b: POS_11, b: POS_01};
         default: m = '{r: POS_11, g_a: POS_01, g_b: POS_10, b: POS_00};
      endcase
      return m;
   endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Single-port line buffer with registered read; read data holds until the
// next read so a quad can wait out arbitrary input gaps.
module line_buffer_ram #(
   parameter int unsigned DEPTH      = 644,
   parameter int unsigned WIDTH      = 20,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  enable,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [WIDTH-1:0]      write_data,
   output logic [WIDTH-1:0]      read_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (enable) begin
         if (write_enable) begin
            mem[address] <= write_data;
         end else begin
            read_data <= mem[address];
         end
      end
   end

endmodule

// File: rtl/bayer_binning_demosaic.sv
// Streaming 2x2 Bayer demosaic: one half-resolution RGB pixel per quad, with
// an output-coordinate crop window and sticky line-overflow reporting.
module bayer_binning_demosaic
   import camera_pkg::*;
#(
   parameter int unsigned PIXEL_WIDTH = 10,
   parameter int unsigned MAX_X_SIZE  = 1288,
   parameter int unsigned COORD_WIDTH = 11
) (
   input  logic                     clock_in,
   input  logic                     reset_in,
   input  logic [PIXEL_WIDTH-1:0]   pixel_data_in,
   input  logic                     pixel_valid_in,
   input  logic                     line_valid_in,
   input  logic                     frame_valid_in,
   input  logic [1:0]               bayer_pattern_in,
   input  logic [COORD_WIDTH-1:0]   x_offset_in,
   input  logic [COORD_WIDTH-1:0]   x_size_in,
   input  logic [COORD_WIDTH-1:0]   y_offset_in,
   input  logic [COORD_WIDTH-1:0]   y_size_in,
   output logic [3*PIXEL_WIDTH-1:0] rgb_out,
   output logic                     rgb_valid_out,
   output logic                     line_end_out,
   output logic                     frame_end_out,
   output logic                     overflow_out
);

   localparam int unsigned RAM_DEPTH  = MAX_X_SIZE / 2;
   localparam int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH);
   localparam int unsigned WORD_WIDTH = 2 * PIXEL_WIDTH;
   localparam int unsigned SUM_WIDTH  = COORD_WIDTH + 1;
   localparam int unsigned GSUM_WIDTH = PIXEL_WIDTH + 1;
   localparam logic [COORD_WIDTH-1:0] X_LIMIT = COORD_WIDTH'(MAX_X_SIZE);

   logic                   frame_q;
   logic                   line_q;
   logic                   active;
   bayer_pattern_t         pattern_q;
   logic [COORD_WIDTH-1:0] x_off_q;
   logic [COORD_WIDTH-1:0] x_size_q;
   logic [COORD_WIDTH-1:0] y_off_q;
   logic [COORD_WIDTH-1:0] y_size_q;
   logic [COORD_WIDTH-1:0] x_count;
   logic [COORD_WIDTH-1:0] row_count;
   logic [PIXEL_WIDTH-1:0] hold_q;
   logic [WORD_WIDTH-1:0]  ram_rdata;

   logic                   frame_rise_c;
   logic                   frame_fall_c;
   logic                   line_fall_c;
   logic                   accept_c;
   logic                   in_range_c;
   logic                   odd_row_c;
   logic                   odd_x_c;
   logic [SUM_WIDTH-1:0]   ox_c;
   logic [SUM_WIDTH-1:0]   oy_c;
   logic                   x_in_win_c;
   logic                   y_in_win_c;
   logic                   emit_c;
   logic                   ram_en_c;
   logic                   ram_we_c;
   logic [ADDR_WIDTH-1:0]  ram_addr_c;
   logic [WORD_WIDTH-1:0]  ram_wdata_c;
   logic [PIXEL_WIDTH-1:0] quad_c [4];
   quad_map_t              map_c;
   logic [GSUM_WIDTH-1:0]  g_sum_c;
   logic [3*PIXEL_WIDTH-1:0] rgb_c;

   // Edge detection and pixel qualification; only an armed frame accepts data
   assign frame_rise_c = frame_valid_in & ~frame_q;
   assign frame_fall_c = ~frame_valid_in & frame_q & active;
   assign line_fall_c  = ~line_valid_in & line_q & active;
   assign accept_c     = active & frame_valid_in & line_valid_in & pixel_valid_in;
   assign in_range_c   = x_count < X_LIMIT;
   assign odd_row_c    = row_count[0];
   assign odd_x_c      = x_count[0];

   assign ox_c = SUM_WIDTH'(x_count >> 1);
   assign oy_c = SUM_WIDTH'(row_count >> 1);
   assign x_in_win_c = (ox_c >= SUM_WIDTH'(x_off_q)) &&
                       (ox_c <  SUM_WIDTH'(x_off_q) + SUM_WIDTH'(x_size_q));
   assign y_in_win_c = (oy_c >= SUM_WIDTH'(y_off_q)) &&
                       (oy_c <  SUM_WIDTH'(y_off_q) + SUM_WIDTH'(y_size_q));

   // Even rows write pairs on the odd sample; odd rows read on the even sample
   assign ram_en_c    = accept_c & in_range_c & (odd_row_c ? ~odd_x_c : odd_x_c);
   assign ram_we_c    = ~odd_row_c;
   assign ram_addr_c  = ADDR_WIDTH'(x_count >> 1);
   assign ram_wdata_c = {hold_q, pixel_data_in};

   line_buffer_ram #(
      .DEPTH      (RAM_DEPTH),
      .WIDTH      (WORD_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_line_buffer (
      .clock        (clock_in),
      .enable       (ram_en_c),
      .write_enable (ram_we_c),
      .address      (ram_addr_c),
      .write_data   (ram_wdata_c),
      .read_data    (ram_rdata)
   );

   assign quad_c[0] = ram_rdata[WORD_WIDTH-1:PIXEL_WIDTH];
   assign quad_c[1] = ram_rdata[PIXEL_WIDTH-1:0];
   assign quad_c[2] = hold_q;
   assign quad_c[3] = pixel_data_in;
   assign map_c     = quad_map(pattern_q);
   assign g_sum_c   = GSUM_WIDTH'(quad_c[map_c.g_a]) + GSUM_WIDTH'(quad_c[map_c.g_b]);
   assign rgb_c     = {quad_c[map_c.r], PIXEL_WIDTH'(g_sum_c >> 1), quad_c[map_c.b]};
   assign emit_c    = accept_c & in_range_c & odd_row_c & odd_x_c & x_in_win_c & y_in_win_c;

   // frame_q resets high so a frame already in progress at reset never arms
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         frame_q       <= 1'b1;
         line_q        <= 1'b0;
         active        <= 1'b0;
         pattern_q     <= RGGB;
         x_off_q       <= '0;
         x_size_q      <= '0;
         y_off_q       <= '0;
         y_size_q      <= '0;
         x_count       <= '0;
         row_count     <= '0;
         hold_q        <= '0;
         rgb_out       <= '0;
         rgb_valid_out <= 1'b0;
         line_end_out  <= 1'b0;
         frame_end_out <= 1'b0;
         overflow_out  <= 1'b0;
      end else begin
         frame_q       <= frame_valid_in;
         line_q        <= line_valid_in;
         rgb_valid_out <= emit_c;
         line_end_out  <= line_fall_c & odd_row_c & y_in_win_c;
         frame_end_out <= frame_fall_c;
         if (emit_c) begin
            rgb_out <= rgb_c;
         end
         if (frame_rise_c) begin
            active       <= 1'b1;
            pattern_q    <= bayer_pattern_t'(bayer_pattern_in);
            x_off_q      <= x_offset_in;
            x_size_q     <= x_size_in;
            y_off_q      <= y_offset_in;
            y_size_q     <= y_size_in;
            x_count      <= '0;
            row_count    <= '0;
            overflow_out <= 1'b0;
         end else begin
            if (frame_fall_c) begin
               active <= 1'b0;
            end
            if (line_fall_c) begin
               x_count   <= '0;
               row_count <= row_count + COORD_WIDTH'(1);
            end else if (accept_c) begin
               if (in_range_c) begin
                  x_count <= x_count + COORD_WIDTH'(1);
                  if (!odd_x_c) begin
                     hold_q <= pixel_data_in;
                  end
               end else begin
                  overflow_out <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_bayer_binning_demosaic.sv
// Directed bench for bayer_binning_demosaic: a reference model pushes expected
// RGB samples and their cycle of arrival; a monitor pops and compares them.
module tb_bayer_binning_demosaic;

   localparam int PW   = 10;
   localparam int MAXX = 1288;
   localparam int CW   = 11;

   logic            clock_in = 1'b0;
   logic            reset_in;
   logic [PW-1:0]   pixel_data_in;
   logic            pixel_valid_in;
   logic            line_valid_in;
   logic            frame_valid_in;
   logic [1:0]      bayer_pattern_in;
   logic [CW-1:0]   x_offset_in, x_size_in, y_offset_in, y_size_in;
   logic [3*PW-1:0] rgb_out;
   logic            rgb_valid_out, line_end_out, frame_end_out, overflow_out;

   bayer_binning_demosaic #(.PIXEL_WIDTH(PW), .MAX_X_SIZE(MAXX), .COORD_WIDTH(CW)) dut (
      .clock_in         (clock_in),
      .reset_in         (reset_in),
      .pixel_data_in    (pixel_data_in),
      .pixel_valid_in   (pixel_valid_in),
      .line_valid_in    (line_valid_in),
      .frame_valid_in   (frame_valid_in),
      .bayer_pattern_in (bayer_pattern_in),
      .x_offset_in      (x_offset_in),
      .x_size_in        (x_size_in),
      .y_offset_in      (y_offset_in),
      .y_size_in        (y_size_in),
      .rgb_out          (rgb_out),
      .rgb_valid_out    (rgb_valid_out),
      .line_end_out     (line_end_out),
      .frame_end_out    (frame_end_out),
      .overflow_out     (overflow_out)
   );

   always #5 clock_in = ~clock_in;

   typedef struct {
      logic [3*PW-1:0] rgb;
      int              cyc;
   } exp_t;

   exp_t            sb[$];
   exp_t            mon_e;
   logic [3*PW-1:0] cap[$];
   logic [3*PW-1:0] cap_a[$];
   int checks = 0, errors = 0;
   int cyc = 0;
   int le_cnt = 0, fe_cnt = 0, out_cnt = 0;
   int le0, fe0, out0;
   int m_pat, m_xo, m_xs, m_yo, m_ys, seed;
   bit use_img;
   logic [PW-1:0] img [2][4];

   always @(posedge clock_in) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] get_pix(input int r, input int x);
      if (use_img) return img[r][x];
      return PW'((r * 131 + x * 29 + seed * 7) % 1024);
   endfunction

   function automatic bit in_win(input int ox, input int oy);
      return ox >= m_xo && ox < m_xo + m_xs && oy >= m_yo && oy < m_yo + m_ys;
   endfunction

   function automatic logic [3*PW-1:0] model_rgb(input int r, input int x);
      logic [PW-1:0] p00, p01, p10, p11, rr, bb;
      logic [PW:0]   gs;
      p00 = get_pix(r - 1, x - 1);
      p01 = get_pix(r - 1, x);
      p10 = get_pix(r, x - 1);
      p11 = get_pix(r, x);
      case (m_pat)
         0:       begin rr = p00; bb = p11; gs = {1'b0, p01} + {1'b0, p10}; end
         1:       begin rr = p01; bb = p10; gs = {1'b0, p00} + {1'b0, p11}; end
         2:       begin rr = p10; bb = p01; gs = {1'b0, p00} + {1'b0, p11}; end
         default: begin rr = p11; bb = p00; gs = {1'b0, p01} + {1'b0, p10}; end
      endcase
      return {rr, gs[PW:1], bb};
   endfunction

   task automatic arm(input int pat, input int xo, input int xs, input int yo, input int ys);
      m_pat = pat; m_xo = xo; m_xs = xs; m_yo = yo; m_ys = ys;
      @(negedge clock_in);
      bayer_pattern_in = 2'(pat);
      x_offset_in = CW'(xo); x_size_in = CW'(xs);
      y_offset_in = CW'(yo); y_size_in = CW'(ys);
      frame_valid_in = 1'b1;
      le0 = le_cnt; fe0 = fe_cnt; out0 = out_cnt;
      @(negedge clock_in);
   endtask

   task automatic send_rows(input int nrows, input int ncols, input int gap_max,
                            input bit exp_en, input bit ovf_chk, input bit coincide);
      for (int r = 0; r < nrows; r++) begin
         @(negedge clock_in);
         line_valid_in = 1'b1;
         for (int x = 0; x < ncols; x++) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (gap) begin
               @(negedge clock_in);
               pixel_valid_in = 1'b0;
            end
            @(negedge clock_in);
            if (ovf_chk && r == 0 && x == MAXX)     check("overflow_before_excess", 32'(overflow_out), 0);
            if (ovf_chk && r == 0 && x == MAXX + 1) check("overflow_after_excess", 32'(overflow_out), 1);
            pixel_valid_in = 1'b1;
            pixel_data_in  = get_pix(r, x);
            if (exp_en && (r % 2) == 1 && (x % 2) == 1 && x < MAXX && in_win(x / 2, r / 2))
               sb.push_back('{rgb: model_rgb(r, x), cyc: cyc + 1});
         end
         @(negedge clock_in);
         pixel_valid_in = 1'b0;
         line_valid_in  = 1'b0;
         if (coincide && r == nrows - 1) frame_valid_in = 1'b0;
         @(negedge clock_in);
      end
   endtask

   task automatic end_frame(input bit chk_fe, input int exp_le, input int exp_out);
      @(negedge clock_in);
      frame_valid_in = 1'b0;
      line_valid_in  = 1'b0;
      pixel_valid_in = 1'b0;
      repeat (3) @(negedge clock_in);
      if (chk_fe) check("frame_end_pulses", fe_cnt - fe0, 1);
      check("line_end_pulses", le_cnt - le0, exp_le);
      check("rgb_count", out_cnt - out0, exp_out);
      check("scoreboard_empty", sb.size(), 0);
   endtask

   initial begin
      reset_in = 1'b1; pixel_data_in = '0; pixel_valid_in = 1'b0;
      line_valid_in = 1'b0; frame_valid_in = 1'b0; bayer_pattern_in = 2'd0;
      x_offset_in = '0; x_size_in = '0; y_offset_in = '0; y_size_in = '0;
      seed = 0; use_img = 1'b1;
      img[0][0] = 10'd100; img[0][1] = 10'd200; img[0][2] = 10'd300; img[0][3] = 10'd400;
      img[1][0] = 10'd500; img[1][1] = 10'd600; img[1][2] = 10'd700; img[1][3] = 10'd800;

      fork
         forever begin
            @(negedge clock_in);
            if (rgb_valid_out) begin
               out_cnt++;
               cap.push_back(rgb_out);
               checks++;
               assert (sb.size() != 0) else begin
                  errors++;
                  $error("FAIL unexpected_rgb: observed %0h expected no output", rgb_out);
               end
               if (sb.size() != 0) begin
                  mon_e = sb.pop_front();
                  check("rgb_value", 32'(rgb_out), 32'(mon_e.rgb));
                  check("rgb_latency", cyc, mon_e.cyc);
               end
            end
            if (line_end_out)  le_cnt++;
            if (frame_end_out) fe_cnt++;
         end
      join_none

      // Reset values
      repeat (3) @(negedge clock_in);
      check("reset_rgb", 32'(rgb_out), 0);
      check("reset_valid", 32'(rgb_valid_out), 0);
      check("reset_line_end", 32'(line_end_out), 0);
      check("reset_frame_end", 32'(frame_end_out), 0);
      check("reset_overflow", 32'(overflow_out), 0);
      reset_in = 1'b0;
      repeat (2) @(negedge clock_in);

      // RGGB 4x2 frame
      arm(0, 0, 2047, 0, 2047);
      send_rows(2, 4, 0, 1'b1, 1'b0, 1'b0);
      end_frame(1'b1, 1, 2);
      check("rggb_last_rgb", 32'(rgb_out), 32'({10'd300, 10'd550, 10'd800}));

      // BGGR, pattern input changed after arming
      arm(3, 0, 2047, 0, 2047);
      bayer_pattern_in = 2'd0;
      send_rows(2, 4, 0, 1'b1, 1'b0, 1'b0);
      end_frame(1'b1, 1, 2);
      check("bggr_last_rgb", 32'(rgb_out), 32'({10'd800, 10'd550, 10'd300}));

      // 8x8 GRBG frame with crop; line and frame fall together at the end
      use_img = 1'b0; seed = 1;
      arm(1, 1, 2, 2, 1);
      send_rows(8, 8, 0, 1'b1, 1'b0, 1'b1);
      end_frame(1'b1, 1, 2);

      // Overlong lines
      seed = 2;
      arm(2, 0, 2047, 0, 2047);
      send_rows(2, MAXX + 3, 0, 1'b1, 1'b1, 1'b0);
      end_frame(1'b1, 1, MAXX / 2);
      check("overflow_sticky", 32'(overflow_out), 1);

      // Odd-sized frame, gap-free then with random gaps
      seed = 3;
      arm(0, 0, 2047, 0, 2047);
      check("overflow_cleared_on_arm", 32'(overflow_out), 0);
      cap.delete();
      send_rows(5, 7, 0, 1'b1, 1'b0, 1'b0);
      end_frame(1'b1, 2, 6);
      cap_a = cap;
      cap.delete();
      arm(0, 0, 2047, 0, 2047);
      send_rows(5, 7, 5, 1'b1, 1'b0, 1'b0);
      end_frame(1'b1, 2, 6);
      check("gap_run_length", cap.size(), cap_a.size());
      for (int i = 0; i < cap_a.size() && i < cap.size(); i++)
         check("gap_run_pixel", 32'(cap[i]), 32'(cap_a[i]));

      // Reset mid-frame with frame_valid held high
      seed = 4;
      arm(0, 0, 2047, 0, 2047);
      send_rows(1, 6, 0, 1'b0, 1'b0, 1'b0);
      reset_in = 1'b1;
      @(negedge clock_in);
      check("midreset_rgb", 32'(rgb_out), 0);
      check("midreset_valid", 32'(rgb_valid_out), 0);
      check("midreset_line_end", 32'(line_end_out), 0);
      check("midreset_overflow", 32'(overflow_out), 0);
      reset_in = 1'b0;
      send_rows(4, 6, 0, 1'b0, 1'b0, 1'b0);
      end_frame(1'b0, 0, 0);

      // Next frame after re-arm works normally
      use_img = 1'b1;
      arm(0, 0, 2047, 0, 2047);
      send_rows(2, 4, 0, 1'b1, 1'b0, 1'b0);
      end_frame(1'b1, 1, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
